sample_packer: RTL and testbench

- Single-clock, parametrised successor to the fast-sample-to-wide-word buffer used for DDS and ADC capture.
- Packs a multi-channel sample stream into wide words, LANES samples per channel per word.
- Adds selectable decimation, frame-start realignment, a valid/ready output handshake, and overflow accounting.
- Sits between the DDS/ADC sample source and the operations/record datapath.

---
 rtl/sample_packer_pkg.sv | 24 ++
 rtl/sample_decimator.sv | 38 +++
 rtl/sample_packer.sv | 97 +++++++++
 tb/tb_sample_packer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sample_packer_pkg.sv
// sample_packer_pkg: shared decimation encodings and width/offset helpers for the sample packer
package sample_packer_pkg;
  localparam logic [1:0] DECIM_1 = 2'd0;
  localparam logic [1:0] DECIM_2 = 2'd1;
  localparam logic [1:0] DECIM_4 = 2'd2;
  localparam logic [1:0] DECIM_8 = 2'd3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int out_width(input int sample_w, input int channels, input int lanes);
    return sample_w * channels * lanes;
  endfunction
  function automatic int lane_width(input int lanes);
    return lanes > 1 ? clog2(lanes) : 1;
  endfunction
  // LSB of channel c, lane l; lane 0 of channel 0 sits at the top of the word
  function automatic int lane_lsb(input int out_w, input int sample_w, input int lanes,
                                  input int c, input int l);
    return out_w - (c * lanes + l + 1) * sample_w;
  endfunction
endpackage

// File: rtl/sample_decimator.sv
// sample_decimator: keeps 1 of every 2^sel accepted samples; sel is held between restarts
module sample_decimator
  import sample_packer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [1:0] decim_sel,
  output logic       keep
);
  logic [2:0] cnt;
  logic [2:0] mask;
  logic [1:0] sel_q;
  logic [1:0] sel_eff;
  logic       held;
  logic       restart;
  assign restart = in_valid & in_sof;
  // until the first sample after reset the live setting is used, then it is frozen
  assign sel_eff = (restart | ~held) ? decim_sel : sel_q;
  assign mask    = ~(3'b111 << sel_eff);
  assign keep    = in_valid & ~clear & (restart | cnt == 3'd0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      sel_q <= DECIM_1;
      held  <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      sel_q <= decim_sel;
      held  <= 1'b1;
    end else if (in_valid) begin
      cnt   <= (restart ? 3'd1 : cnt + 3'd1) & mask;
      sel_q <= sel_eff;
      held  <= 1'b1;
    end
endmodule

// File: rtl/sample_packer.sv
// sample_packer: packs a decimated multi-channel sample stream into wide words with a valid/ready output
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter  int SAMPLE_W = 16,
  parameter  int CHANNELS = 2,
  parameter  int LANES    = 4,
  parameter  int CNT_W    = 16,
  localparam int OUT_W    = out_width(SAMPLE_W, CHANNELS, LANES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic [1:0]                   decim_sel,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic [SAMPLE_W*CHANNELS-1:0] in_data,
  output logic [OUT_W-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sof,
  output logic                         overflow,
  output logic [CNT_W-1:0]             drop_count
);
  localparam int LW = lane_width(LANES);
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);
  logic                keep;
  logic                complete;
  logic                load;
  logic                word_sof;
  logic                asm_sof;
  logic [LW-1:0]       lane_cnt;
  logic [LW-1:0]       lane;
  logic [OUT_W-1:0]    word;
  logic [SAMPLE_W-1:0] asm_q [CHANNELS][LANES];
  sample_decimator u_decim (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .decim_sel(decim_sel),
    .keep     (keep)
  );
  // a frame start forces lane 0, silently abandoning any partial word
  assign lane     = in_sof ? '0 : lane_cnt;
  assign complete = keep & (lane == LAST);
  assign word_sof = lane == '0 ? in_sof : asm_sof;
  assign load     = ~out_valid | out_ready;
  always_comb begin
    word = '0;
    for (int c = 0; c < CHANNELS; c++)
      for (int l = 0; l < LANES; l++)
        word[lane_lsb(OUT_W, SAMPLE_W, LANES, c, l) +: SAMPLE_W] =
          l == LANES - 1 ? in_data[SAMPLE_W*(CHANNELS-c)-1 -: SAMPLE_W] : asm_q[c][l];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lane_cnt <= '0;
      asm_sof  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++)
        for (int l = 0; l < LANES; l++)
          asm_q[c][l] <= '0;
    end else if (clear) begin
      lane_cnt <= '0;
      asm_sof  <= 1'b0;
    end else if (keep) begin
      lane_cnt <= complete ? '0 : lane + 1'b1;
      if (lane == '0) asm_sof <= in_sof;
      for (int c = 0; c < CHANNELS; c++)
        asm_q[c][lane] <= in_data[SAMPLE_W*(CHANNELS-c)-1 -: SAMPLE_W];
    end
  // a word completing against a stalled, full output register is dropped and counted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (complete & load) begin
      out_data  <= word;
      out_sof   <= word_sof;
      out_valid <= 1'b1;
    end else begin
      if (out_valid & out_ready) out_valid <= 1'b0;
      if (complete) begin
        overflow   <= 1'b1;
        drop_count <= &drop_count ? drop_count : drop_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: directed scenarios plus random traffic checked against a queue-based reference model
module tb_sample_packer;
  import sample_packer_pkg::*;
  localparam int SW = 16, CH = 2, LN = 4, CW = 16, OW = SW * CH * LN;
  logic          clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic          in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
  logic [1:0]    decim_sel = DECIM_1;
  logic [SW*CH-1:0] in_data = '0;
  logic [OW-1:0] out_data;
  logic          out_valid, out_sof, overflow;
  logic [CW-1:0] drop_count;
  int checks = 0, errors = 0;
  logic [SW*CH-1:0] part[$];
  logic [OW-1:0] m_data, exp_w;
  bit  p_sof, m_valid, m_sof, m_ovf, m_held;
  int  m_drop, m_sel, m_idx, nvalid;
  logic [SW*CH-1:0] d;
  sample_packer #(.SAMPLE_W(SW), .CHANNELS(CH), .LANES(LN), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .decim_sel(decim_sel),
    .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .overflow(overflow), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    part.delete();
    p_sof = 0; m_data = '0; m_valid = 0; m_sof = 0; m_ovf = 0; m_drop = 0;
    m_sel = 0; m_held = 0; m_idx = 0;
  endtask
  function automatic logic [OW-1:0] pack_word();
    logic [OW-1:0] w;
    logic [SW*CH-1:0] s;
    w = '0;
    for (int c = 0; c < CH; c++)
      for (int l = 0; l < LN; l++) begin
        s = part[l];
        w = (w << SW) | OW'(SW'(s >> (SW * (CH - 1 - c))));
      end
    return w;
  endfunction
  task automatic step();
    bit kept, fire;
    if (clear) begin
      part.delete();
      m_valid = 0; m_sof = 0; m_ovf = 0; m_drop = 0;
      m_sel = int'(decim_sel); m_held = 1; m_idx = 0;
      return;
    end
    kept = 0;
    if (in_valid) begin
      if (in_sof) begin
        part.delete(); m_sel = int'(decim_sel); m_held = 1; m_idx = 0;
      end else if (!m_held) begin
        m_sel = int'(decim_sel); m_held = 1;
      end
      kept = (m_idx % (1 << m_sel)) == 0;
      m_idx++;
    end
    fire = m_valid && out_ready;
    if (kept) begin
      if (part.size() == 0) p_sof = in_sof;
      part.push_back(in_data);
    end
    if (kept && part.size() == LN) begin
      if (!m_valid || out_ready) begin
        m_data = pack_word(); m_sof = p_sof; m_valid = 1;
      end else begin
        m_ovf = 1;
        if (m_drop < (1 << CW) - 1) m_drop++;
      end
      part.delete();
    end else if (fire) m_valid = 0;
  endtask
  task automatic check_all();
    check("out_valid", out_valid, m_valid);
    check("out_sof", out_sof, m_sof);
    check("overflow", overflow, m_ovf);
    check("drop_count", drop_count, m_drop);
    check("out_data", out_data, m_data);
  endtask
  task automatic tick(input bit v, input bit s, input logic [SW*CH-1:0] dd, input bit r, input bit c);
    in_valid = v; in_sof = s; in_data = dd; out_ready = r; clear = c;
    step();
    @(negedge clk);
    check_all();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    rst_n = 1'b1;
    check_all();
    // 1: plain packing
    for (int i = 1; i <= 4; i++) tick(1, 0, {16'(i), 16'(16 + i)}, 1, 0);
    check("t1 valid", out_valid, 1);
    check("t1 data", out_data, 128'h0001_0002_0003_0004_0011_0012_0013_0014);
    check("t1 sof", out_sof, 0);
    tick(0, 0, '0, 1, 0);
    // 2: decimate by 4
    decim_sel = DECIM_4;
    tick(0, 0, '0, 1, 1);
    nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1, 0, {16'(i), 16'(i)}, 1, 0);
      if (out_valid) nvalid++;
      if (i == 11) check("t2 early", out_valid, 0);
      if (i == 12) begin
        check("t2 valid", out_valid, 1);
        check("t2 data", out_data, 128'h0000_0004_0008_000C_0000_0004_0008_000C);
      end
    end
    check("t2 words", nvalid, 1);
    decim_sel = DECIM_1;
    tick(0, 0, '0, 1, 1);
    // 3: stall then overflow
    exp_w = '0;
    for (int i = 0; i < 8; i++) begin
      d = {16'(100 + i), 16'(200 + i)};
      if (i < 4) exp_w = {exp_w[OW-SW-1:0], 16'(100 + i)};
      tick(1, 0, d, 0, 0);
    end
    exp_w = {exp_w[OW/2-1:0], 16'd200, 16'd201, 16'd202, 16'd203};
    check("t3 held", out_data, exp_w);
    check("t3 ovf", overflow, 1);
    check("t3 drops", drop_count, 1);
    tick(0, 0, '0, 1, 0);
    check("t3 drained", out_valid, 0);
    check("t3 ovf sticky", overflow, 1);
    // 4: frame start realignment
    tick(1, 0, 32'h1111_2222, 1, 0);
    tick(1, 0, 32'h3333_4444, 1, 0);
    tick(1, 1, {16'hAAAA, 16'h5555}, 1, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, {16'(i + 1), 16'(i + 9)}, 1, 0);
    check("t4 valid", out_valid, 1);
    check("t4 sof", out_sof, 1);
    check("t4 data", out_data, 128'hAAAA_0001_0002_0003_5555_0009_000A_000B);
    tick(0, 0, '0, 1, 0);
    // 5: clear with the 4th sample
    check("t5 pre ovf", overflow, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, $urandom, 1, 0);
    tick(1, 0, $urandom, 1, 1);
    check("t5 valid", out_valid, 0);
    check("t5 ovf", overflow, 0);
    check("t5 drops", drop_count, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, {16'(i + 5), 16'(i + 7)}, 1, 0);
    check("t5 data", out_data, 128'h0005_0006_0007_0008_0007_0008_0009_000A);
    check("t5 valid2", out_valid, 1);
    // 6: async reset mid-word
    tick(0, 0, '0, 0, 0);
    for (int i = 0; i < 6; i++) tick(1, 0, $urandom, 0, 0);
    check("t6 pre valid", out_valid, 1);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("t6 rst valid", out_valid, 0);
    check("t6 rst data", out_data, 0);
    check("t6 rst sof", out_sof, 0);
    check("t6 rst ovf", overflow, 0);
    check("t6 rst drops", drop_count, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick(1, 0, {16'(i + 32), 16'(i + 48)}, 1, 0);
    check("t6 data", out_data, 128'h0020_0021_0022_0023_0030_0031_0032_0033);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 30) == 0) decim_sel = 2'($urandom);
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
